// File: rtl/riscv_enc_pkg.sv
// Shared RV32I encoder definitions: opcodes, funct fields, mnemonic constants,
// FIFO entry type and the mnemonic lookup used by stage 1.
package riscv_enc_pkg;

    localparam logic [6:0]  OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0]  OPC_ITYPE  = 7'b0010011;

    localparam logic [2:0]  F3_ADD     = 3'b000;
    localparam logic [2:0]  F3_SLL     = 3'b001;
    localparam logic [2:0]  F3_SLTU    = 3'b011;
    localparam logic [2:0]  F3_XOR     = 3'b100;
    localparam logic [2:0]  F3_SR      = 3'b101;
    localparam logic [2:0]  F3_OR      = 3'b110;
    localparam logic [2:0]  F3_AND     = 3'b111;

    localparam logic [6:0]  F7_BASE    = 7'b0000000;
    localparam logic [6:0]  F7_ALT     = 7'b0100000;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef enum logic [1:0] {CLS_R, CLS_I, CLS_ISHIFT, CLS_BAD} op_class_e;

    // ASCII mnemonics, right-justified and zero-padded
    localparam logic [63:0] MN_ADD   = 64'h0000_0000_0041_4444;
    localparam logic [63:0] MN_SUB   = 64'h0000_0000_0053_5542;
    localparam logic [63:0] MN_SLL   = 64'h0000_0000_0053_4C4C;
    localparam logic [63:0] MN_XOR   = 64'h0000_0000_0058_4F52;
    localparam logic [63:0] MN_SRL   = 64'h0000_0000_0053_524C;
    localparam logic [63:0] MN_SRA   = 64'h0000_0000_0053_5241;
    localparam logic [63:0] MN_OR    = 64'h0000_0000_0000_4F52;
    localparam logic [63:0] MN_AND   = 64'h0000_0000_0041_4E44;
    localparam logic [63:0] MN_ADDI  = 64'h0000_0000_4144_4449;
    localparam logic [63:0] MN_SLLI  = 64'h0000_0000_534C_4C49;
    localparam logic [63:0] MN_SLTIU = 64'h0000_0053_4C54_4955;
    localparam logic [63:0] MN_XORI  = 64'h0000_0000_584F_5249;
    localparam logic [63:0] MN_SRLI  = 64'h0000_0000_5352_4C49;
    localparam logic [63:0] MN_SRAI  = 64'h0000_0000_5352_4149;
    localparam logic [63:0] MN_ORI   = 64'h0000_0000_004F_5249;
    localparam logic [63:0] MN_ANDI  = 64'h0000_0000_414E_4449;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } enc_entry_t;

    typedef struct packed {
        op_class_e  cls;
        logic [2:0] funct3;
        logic [6:0] funct7;
    } op_info_t;

    function automatic op_info_t lookup_mnem(input logic [63:0] mnem);
        op_info_t info;
        case (mnem)
            MN_ADD:   info = '{CLS_R,      F3_ADD,  F7_BASE};
            MN_SUB:   info = '{CLS_R,      F3_ADD,  F7_ALT};
            MN_SLL:   info = '{CLS_R,      F3_SLL,  F7_BASE};
            MN_XOR:   info = '{CLS_R,      F3_XOR,  F7_BASE};
            MN_SRL:   info = '{CLS_R,      F3_SR,   F7_BASE};
            MN_SRA:   info = '{CLS_R,      F3_SR,   F7_ALT};
            MN_OR:    info = '{CLS_R,      F3_OR,   F7_BASE};
            MN_AND:   info = '{CLS_R,      F3_AND,  F7_BASE};
            MN_ADDI:  info = '{CLS_I,      F3_ADD,  F7_BASE};
            MN_SLTIU: info = '{CLS_I,      F3_SLTU, F7_BASE};
            MN_XORI:  info = '{CLS_I,      F3_XOR,  F7_BASE};
            MN_ORI:   info = '{CLS_I,      F3_OR,   F7_BASE};
            MN_ANDI:  info = '{CLS_I,      F3_AND,  F7_BASE};
            MN_SLLI:  info = '{CLS_ISHIFT, F3_SLL,  F7_BASE};
            MN_SRLI:  info = '{CLS_ISHIFT, F3_SR,   F7_BASE};
            MN_SRAI:  info = '{CLS_ISHIFT, F3_SR,   F7_ALT};
            default:  info = '{CLS_BAD,    F3_ADD,  F7_BASE};
        endcase
        return info;
    endfunction

endpackage

// File: rtl/enc_fifo.sv
// Synchronous show-ahead FIFO of encoded words; the head entry is visible
// combinationally and flush takes priority over any write or read.
module enc_fifo
    import riscv_enc_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_en,
    input  enc_entry_t               wr_data,
    input  logic                     rd_en,
    output enc_entry_t               rd_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    enc_entry_t [DEPTH-1:0] mem;
    logic [AW-1:0]          wr_ptr_reg;
    logic [AW-1:0]          rd_ptr_reg;
    logic [AW:0]            count_reg;
    logic                   do_wr;
    logic                   do_rd;

    assign do_wr = wr_en && !flush;
    assign do_rd = rd_en && (count_reg != '0) && !flush;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            enc_entry_t entry_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_reg <= '0;
                end else if (do_wr && (wr_ptr_reg == AW'(gi))) begin
                    entry_reg <= wr_data;
                end
            end
            assign mem[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr_reg];
    assign count   = count_reg;

endmodule

// File: rtl/instruction_encoder.sv
// Streaming RV32I assembler: mnemonic lookup, field assembly, output FIFO.
// Optional ENCODER_ERR_COUNT_EN adds a saturating unrecognised-mnemonic counter.
module instruction_encoder
    import riscv_enc_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_mnem,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [11:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic [15:0] err_count
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            accept;
    logic [CW-1:0]   fifo_count;
    logic [CW+1:0]   in_flight;

    logic            s1_valid_reg;
    op_info_t        s1_info_reg;
    logic [4:0]      s1_rd_reg;
    logic [4:0]      s1_rs1_reg;
    logic [4:0]      s1_rs2_reg;
    logic [11:0]     s1_imm_reg;

    logic            s2_valid_reg;
    logic [31:0]     s2_instr_reg;
    logic [31:0]     s2_instr_next;
    logic            s2_err_reg;

    logic [31:0]     addr_reg;
    enc_entry_t      wr_entry;
    enc_entry_t      head;

    // Every word in a stage already owns a FIFO slot, so stages never stall.
    assign in_flight = (CW+2)'(fifo_count) + (CW+2)'(s1_valid_reg) + (CW+2)'(s2_valid_reg);
    assign in_ready  = rst_n && !flush && (in_flight < (CW+2)'(DEPTH));
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_info_reg  <= '0;
            s1_rd_reg    <= '0;
            s1_rs1_reg   <= '0;
            s1_rs2_reg   <= '0;
            s1_imm_reg   <= '0;
        end else begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_info_reg <= lookup_mnem(in_mnem);
                s1_rd_reg   <= in_rd;
                s1_rs1_reg  <= in_rs1;
                s1_rs2_reg  <= in_rs2;
                s1_imm_reg  <= in_imm;
            end
        end
    end

    always_comb begin
        s2_instr_next = NOP_INSTR;
        case (s1_info_reg.cls)
            CLS_R:      s2_instr_next = {s1_info_reg.funct7, s1_rs2_reg, s1_rs1_reg,
                                         s1_info_reg.funct3, s1_rd_reg, OPC_RTYPE};
            CLS_I:      s2_instr_next = {s1_imm_reg, s1_rs1_reg,
                                         s1_info_reg.funct3, s1_rd_reg, OPC_ITYPE};
            CLS_ISHIFT: s2_instr_next = {s1_info_reg.funct7, s1_imm_reg[4:0], s1_rs1_reg,
                                         s1_info_reg.funct3, s1_rd_reg, OPC_ITYPE};
            default:    s2_instr_next = NOP_INSTR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_instr_reg <= '0;
            s2_err_reg   <= 1'b0;
        end else begin
            s2_valid_reg <= s1_valid_reg && !flush;
            if (s1_valid_reg) begin
                s2_instr_reg <= s2_instr_next;
                s2_err_reg   <= (s1_info_reg.cls == CLS_BAD);
            end
        end
    end

    // Address is bound when a word leaves stage 2, so order matches the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg <= BASE_ADDR;
        end else if (flush) begin
            addr_reg <= BASE_ADDR;
        end else if (s2_valid_reg) begin
            addr_reg <= addr_reg + 32'd4;
        end
    end

    assign wr_entry = '{instr: s2_instr_reg, addr: addr_reg, err: s2_err_reg};

    enc_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .wr_en   (s2_valid_reg),
        .wr_data (wr_entry),
        .rd_en   (out_valid && out_ready),
        .rd_data (head),
        .count   (fifo_count)
    );

    assign out_valid = (fifo_count != '0);
    assign out_instr = out_valid ? head.instr : 32'h0;
    assign out_addr  = out_valid ? head.addr  : addr_reg;
    assign out_err   = out_valid && head.err;

`ifdef ENCODER_ERR_COUNT_EN
    logic [15:0] err_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_reg <= '0;
        end else if (s2_valid_reg && s2_err_reg && !flush && (err_count_reg != 16'hFFFF)) begin
            err_count_reg <= err_count_reg + 16'd1;
        end
    end

    assign err_count = err_count_reg;
`else
    assign err_count = 16'h0000;
`endif

endmodule
